// File: rtl/bscan_tap_ctl.sv
// bscan_tap_ctl: IEEE 1149.1 TAP controller with IR, bypass register and
// boundary-scan pad control. Everything runs in the i_clk domain. i_tck_en
// marks the cycle that stands for a TCK rising edge.
module bscan_tap_ctl #(
    parameter int              IR_W      = 4,
    parameter logic [IR_W-1:0] OP_EXTEST = IR_W'(4'b0000),
    parameter logic [IR_W-1:0] OP_SAMPLE = IR_W'(4'b0001),
    parameter logic [IR_W-1:0] OP_HIGHZ  = IR_W'(4'b0010)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tck_en,
    input  logic       i_tms,
    input  logic       i_tdi,
    input  logic       i_bso,
    output logic       o_tdo,
    output logic       o_bsr_si,
    output logic       o_shift_dr,
    output logic       o_clock_dr,
    output logic       o_update_dr,
    output logic       o_mode_ctl,
    output logic       o_hiz_l,
    output logic [3:0] o_tap_state
);

    typedef enum logic [3:0] {
        ST_TLR      = 4'd0,
        ST_RTI      = 4'd1,
        ST_SEL_DR   = 4'd2,
        ST_CAP_DR   = 4'd3,
        ST_SH_DR    = 4'd4,
        ST_EX1_DR   = 4'd5,
        ST_PAUSE_DR = 4'd6,
        ST_EX2_DR   = 4'd7,
        ST_UPD_DR   = 4'd8,
        ST_SEL_IR   = 4'd9,
        ST_CAP_IR   = 4'd10,
        ST_SH_IR    = 4'd11,
        ST_EX1_IR   = 4'd12,
        ST_PAUSE_IR = 4'd13,
        ST_EX2_IR   = 4'd14,
        ST_UPD_IR   = 4'd15
    } tap_state_t;

    // Standard 1149.1 tms transition table.
    function automatic tap_state_t f_next_state(input tap_state_t st, input logic tms);
        tap_state_t nxt;
        case (st)
            ST_TLR:      nxt = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      nxt = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   nxt = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   nxt = tms ? ST_EX1_DR   : ST_SH_DR;
            ST_SH_DR:    nxt = tms ? ST_EX1_DR   : ST_SH_DR;
            ST_EX1_DR:   nxt = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: nxt = tms ? ST_EX2_DR   : ST_PAUSE_DR;
            ST_EX2_DR:   nxt = tms ? ST_UPD_DR   : ST_SH_DR;
            ST_UPD_DR:   nxt = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   nxt = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   nxt = tms ? ST_EX1_IR   : ST_SH_IR;
            ST_SH_IR:    nxt = tms ? ST_EX1_IR   : ST_SH_IR;
            ST_EX1_IR:   nxt = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: nxt = tms ? ST_EX2_IR   : ST_PAUSE_IR;
            ST_EX2_IR:   nxt = tms ? ST_UPD_IR   : ST_SH_IR;
            ST_UPD_IR:   nxt = tms ? ST_SEL_DR   : ST_RTI;
            default:     nxt = ST_TLR;
        endcase
        return nxt;
    endfunction

    // Opcodes that route the DR path through the pad boundary-scan chain;
    // everything else (HIGHZ and all unknown codes) uses the bypass bit.
    function automatic logic f_is_bsr(input logic [IR_W-1:0] op);
        return (op == OP_EXTEST) || (op == OP_SAMPLE);
    endfunction

    // Opcodes where the pads are driven from the boundary-scan cells.
    function automatic logic f_is_mode(input logic [IR_W-1:0] op);
        return (op == OP_EXTEST) || (op == OP_HIGHZ);
    endfunction

    tap_state_t      r_state;
    logic [IR_W-1:0] r_ir;
    logic [IR_W-1:0] r_ir_shift;
    logic            r_bypass;
    logic            r_tdo;

    logic            w_bsr_sel;
    logic            w_clock_dr;
    logic            w_update_dr;
    logic            w_shift_dr;
    logic            w_mode_ctl;
    logic            w_hiz_l;

    // TAP state, instruction path, bypass bit and tdo all advance on a TCK strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_TLR;
            r_ir       <= '1;
            r_ir_shift <= '0;
            r_bypass   <= 1'b0;
            r_tdo      <= 1'b0;
        end else begin
            // Active IR: forced to BYPASS while in TLR, loaded on the UpdIR strobe.
            if (r_state == ST_TLR) begin
                r_ir <= '1;
            end else if (i_tck_en && (r_state == ST_UPD_IR)) begin
                r_ir <= r_ir_shift;
            end else begin
                r_ir <= r_ir;
            end

            if (i_tck_en) begin
                r_state <= f_next_state(r_state, i_tms);

                case (r_state)
                    ST_CAP_IR: r_ir_shift <= IR_W'(2'b01);
                    ST_SH_IR:  r_ir_shift <= {i_tdi, r_ir_shift[IR_W-1:1]};
                    default:   r_ir_shift <= r_ir_shift;
                endcase

                case (r_state)
                    ST_CAP_DR: r_bypass <= 1'b0;
                    ST_SH_DR:  r_bypass <= i_tdi;
                    default:   r_bypass <= r_bypass;
                endcase

                // tdo reflects the bit leaving the selected register on this strobe.
                case (r_state)
                    ST_SH_DR: r_tdo <= w_bsr_sel ? i_bso : r_bypass;
                    ST_SH_IR: r_tdo <= r_ir_shift[0];
                    default:  r_tdo <= 1'b0;
                endcase
            end else begin
                r_state    <= r_state;
                r_ir_shift <= r_ir_shift;
                r_bypass   <= r_bypass;
                r_tdo      <= r_tdo;
            end
        end
    end

    // Pad-cell controls; all forced to their idle values while reset is asserted
    // so a reset arriving mid-scan never leaks a clock or update pulse.
    always_comb begin
        w_bsr_sel   = f_is_bsr(r_ir);
        w_clock_dr  = 1'b0;
        w_update_dr = 1'b0;
        w_shift_dr  = 1'b0;
        w_mode_ctl  = 1'b0;
        w_hiz_l     = 1'b1;
        if (i_rst) begin
            w_clock_dr  = 1'b0;
            w_update_dr = 1'b0;
            w_shift_dr  = 1'b0;
            w_mode_ctl  = 1'b0;
            w_hiz_l     = 1'b1;
        end else begin
            w_clock_dr  = i_tck_en && w_bsr_sel &&
                          ((r_state == ST_CAP_DR) || (r_state == ST_SH_DR));
            w_update_dr = i_tck_en && w_bsr_sel && (r_state == ST_UPD_DR);
            w_shift_dr  = (r_state == ST_SH_DR);
            w_mode_ctl  = f_is_mode(r_ir);
            w_hiz_l     = (r_ir != OP_HIGHZ);
        end
    end

    assign o_tdo       = r_tdo;
    assign o_bsr_si    = i_tdi;
    assign o_shift_dr  = w_shift_dr;
    assign o_clock_dr  = w_clock_dr;
    assign o_update_dr = w_update_dr;
    assign o_mode_ctl  = w_mode_ctl;
    assign o_hiz_l     = w_hiz_l;
    assign o_tap_state = r_state;

endmodule

// File: doc/bscan_tap_ctl.md
BSCAN_TAP_CTL -- requirements
Module: bscan_tap_ctl

Interface
REQ-001 The block SHALL have parameter IR_W, default 4, meaning the instruction register width; legal range 2..8.
REQ-002 The block SHALL have parameter OP_EXTEST, default 4'b0000, meaning the EXTEST opcode.
REQ-003 The block SHALL have parameter OP_SAMPLE, default 4'b0001, meaning the SAMPLE/PRELOAD opcode.
REQ-004 The block SHALL have parameter OP_HIGHZ, default 4'b0010, meaning the HIGHZ opcode; all-ones is BYPASS.
REQ-005 clk  input  1  is the single clock; all state SHALL update on its rising edge only.
REQ-006 rst  input  1  is a synchronous, active-high reset.
REQ-007 tck_en  input  1  is a one-clk strobe marking a TCK rising edge; TAP state advances only when it is high.
REQ-008 tms  input  1  is test mode select, sampled when tck_en=1.
REQ-009 tdi  input  1  is test data in, sampled when tck_en=1.
REQ-010 bso  input  1  is serial return from the last pad boundary-scan cell.
REQ-011 tdo  output  1  is registered test data out.
REQ-012 bsr_si  output  1  is serial data into the first pad cell, equal to tdi combinationally.
REQ-013 shift_dr  output  1  is the level select for shift (1) versus capture (0) in pad cells.
REQ-014 clock_dr  output  1  is a one-clk capture/shift enable pulse to pad cells.
REQ-015 update_dr  output  1  is a one-clk update pulse to pad cells.
REQ-016 mode_ctl  output  1  selects the boundary-scan value for pad drive when 1.
REQ-017 hiz_l  output  1  is an active-low pad tristate.
REQ-018 tap_state  output  4  is the current TAP state encoding, for debug.

Function
REQ-019 The FSM SHALL implement the 16 IEEE 1149.1 states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR, encoded 0..15 in that order.
REQ-020 Transitions SHALL occur only on clk edges with tck_en=1 and SHALL follow the standard tms table, e.g. TLR->RTI on tms=0, SelIR->TLR on tms=1, UpdDR/UpdIR->SelDR on tms=1 and ->RTI on tms=0.
REQ-021 With tck_en=0 the FSM and all shift registers SHALL hold and clock_dr/update_dr SHALL be 0.
REQ-022 Five consecutive tck_en strobes with tms=1 SHALL reach TLR from any state.
REQ-023 In CapIR, ir_shift SHALL load {IR_W-2 zeros, 2'b01}; in ShIR it SHALL shift right with tdi entering the MSB.
REQ-024 In UpdIR, active IR SHALL load ir_shift; in TLR, active IR SHALL be all-ones (BYPASS).
REQ-025 Any opcode other than EXTEST, SAMPLE or HIGHZ SHALL decode as BYPASS.
REQ-026 bsr_sel SHALL be 1 for EXTEST or SAMPLE; HIGHZ and BYPASS select the 1-bit bypass register.
REQ-027 The bypass register SHALL load 0 in CapDR and load tdi in ShDR.
REQ-028 clock_dr SHALL be 1 for exactly the clk cycle with tck_en=1, bsr_sel=1, and state CapDR or ShDR.
REQ-029 update_dr SHALL be 1 for exactly the clk cycle with tck_en=1, bsr_sel=1, and state UpdDR.
REQ-030 shift_dr SHALL be 1 whenever state is ShDR, independent of tck_en.
REQ-031 mode_ctl SHALL be 1 when active IR is EXTEST or HIGHZ; hiz_l SHALL be 0 only when active IR is HIGHZ.
REQ-032 On tck_en=1, tdo SHALL load: bso in ShDR with bsr_sel; the bypass bit in ShDR otherwise; ir_shift[0] in ShIR; 0 in all other states.
REQ-033 Entering ShDR then leaving via Ex1DR after N strobes SHALL produce exactly N+1 clock_dr pulses, counting the CapDR pulse.
REQ-034 PauseDR/PauseIR SHALL hold all shift contents and SHALL produce no pulses.

Reset
REQ-035 When rst=1 at a clk edge, regardless of tck_en, the block SHALL set tap_state=TLR(0), active IR all-ones, ir_shift 0, bypass 0, tdo 0.
REQ-036 During and after reset until a new IR update, outputs SHALL be shift_dr=0, clock_dr=0, update_dr=0, mode_ctl=0, hiz_l=1.
REQ-037 rst asserted mid-shift SHALL abort the shift with no update_dr pulse.

Verification
REQ-038 rst, then 5 strobes tms=1 -> tap_state=0, mode_ctl=0, hiz_l=1, IR=4'b1111.
REQ-039 Load IR 4'b0000 via ShIR (tdi LSB-first) -> tdo shifts out 1,0,0,0; after UpdIR mode_ctl=1, hiz_l=1.
REQ-040 EXTEST, CapDR + 8 ShDR strobes, bso tied to delayed tdi -> 9 clock_dr pulses, 1 update_dr pulse, tdo equals bso per strobe.
REQ-041 Load HIGHZ -> hiz_l=0, mode_ctl=1; a DR scan shifts through bypass (1-strobe tdi->tdo delay) with no clock_dr pulse.
REQ-042 Load 4'b0110 -> behaves as BYPASS; tck_en held 0 for 20 clk in ShDR -> no state change, no pulses.
REQ-043 rst pulsed during ShDR -> next cycle tap_state=0, no update_dr, IR=BYPASS.
